// File: rtl/command_handler_pkg.sv
// Shared definitions for the VT52 command handler: geometry defaults,
// control-byte codes and the FSM state type.
// Optional feature macro: VT52_DIRECT_CURSOR_EN adds the ESC Y row/col states.
package command_handler_pkg;

    localparam int unsigned DEF_ROWS          = 24;
    localparam int unsigned DEF_COLS          = 80;
    localparam int unsigned DEF_ROW_BITS      = 5;
    localparam int unsigned DEF_COL_BITS      = 7;
    localparam int unsigned DEF_ADDR_BITS     = 11;
    localparam int unsigned DEF_PAST_LAST_ROW = DEF_ROWS * DEF_COLS;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_FILL,
        ST_SCROLL
`ifdef VT52_DIRECT_CURSOR_EN
        , ST_ESC_Y_ROW,
        ST_ESC_Y_COL
`endif
    } state_t;

endpackage

// File: rtl/command_handler_if.sv
// Byte-stream input handshake plus character-buffer / cursor update bus.
// slave = command handler side, master = byte source / buffer consumer side.
interface command_handler_if
    import command_handler_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned COL_BITS  = DEF_COL_BITS,
    parameter int unsigned ROW_BITS  = DEF_ROW_BITS
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 busy;
    logic [ADDR_BITS-1:0] buffer_waddr;
    logic [7:0]           buffer_din;
    logic                 buffer_wen;
    logic [ADDR_BITS-1:0] buffer_first_char;
    logic                 buffer_first_char_wen;
    logic [COL_BITS-1:0]  new_cursor_x;
    logic [ROW_BITS-1:0]  new_cursor_y;
    logic                 new_cursor_wen;

    modport slave (
        input  in_data, in_valid,
        output in_ready, busy,
        output buffer_waddr, buffer_din, buffer_wen,
        output buffer_first_char, buffer_first_char_wen,
        output new_cursor_x, new_cursor_y, new_cursor_wen
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, busy,
        input  buffer_waddr, buffer_din, buffer_wen,
        input  buffer_first_char, buffer_first_char_wen,
        input  new_cursor_x, new_cursor_y, new_cursor_wen
    );
endinterface

// File: rtl/command_handler_addr_wrap.sv
// Circular buffer address adder: (base + offset) mod PAST_LAST_ROW.
// Both operands must already be below PAST_LAST_ROW, so one subtract suffices.
module buffer_addr_wrap
    import command_handler_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
    parameter int unsigned PAST_LAST_ROW = DEF_PAST_LAST_ROW
) (
    input  logic [ADDR_BITS-1:0] i_base,
    input  logic [ADDR_BITS-1:0] i_offset,
    output logic [ADDR_BITS-1:0] o_addr
);
    localparam logic [ADDR_BITS:0] L_PLR = (ADDR_BITS+1)'(PAST_LAST_ROW);

    logic [ADDR_BITS:0] w_sum;
    logic [ADDR_BITS:0] w_wrapped;

    assign w_sum     = {1'b0, i_base} + {1'b0, i_offset};
    assign w_wrapped = w_sum - L_PLR;
    assign o_addr    = (w_sum >= L_PLR) ? w_wrapped[ADDR_BITS-1:0] : w_sum[ADDR_BITS-1:0];
endmodule

// File: rtl/command_handler.sv
// VT52-style command handler: turns the terminal byte stream into character
// buffer writes, cursor updates and scroll-origin updates on a circular buffer.
// Optional feature macro: VT52_DIRECT_CURSOR_EN (ESC Y row col addressing).
module command_handler
    import command_handler_pkg::*;
#(
    parameter int unsigned ROWS          = DEF_ROWS,
    parameter int unsigned COLS          = DEF_COLS,
    parameter int unsigned ROW_BITS      = DEF_ROW_BITS,
    parameter int unsigned COL_BITS      = DEF_COL_BITS,
    parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
    parameter int unsigned PAST_LAST_ROW = ROWS * COLS
) (
    input  logic             clk,
    input  logic             clr,
    command_handler_if.slave bus
);
    localparam logic [ADDR_BITS-1:0] L_COLS   = ADDR_BITS'(COLS);
    localparam logic [ADDR_BITS-1:0] L_UP     = ADDR_BITS'(PAST_LAST_ROW - COLS);
    localparam logic [ADDR_BITS-1:0] L_ONE    = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   L_PLR    = (ADDR_BITS+1)'(PAST_LAST_ROW);
    localparam logic [COL_BITS-1:0]  L_LAST_X = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0]  L_LAST_Y = ROW_BITS'(ROWS - 1);

    state_t               r_state, w_state;
    logic [COL_BITS-1:0]  r_cur_x, w_x;
    logic [ROW_BITS-1:0]  r_cur_y, w_y;
    logic [ADDR_BITS-1:0] r_first_char, w_fc;
    logic [ADDR_BITS-1:0] r_line_base, w_lb;
    logic [ADDR_BITS-1:0] r_fill_addr, w_fill_addr;
    logic [ADDR_BITS:0]   r_fill_cnt, w_fill_cnt;
    logic [ADDR_BITS-1:0] r_waddr, w_waddr;
    logic [7:0]           r_din, w_din;
    logic                 r_wen, w_wen;
    logic                 r_fc_wen, w_fc_wen;
    logic                 r_cur_wen, w_cur_wen;
    logic                 r_in_ready, r_busy;

    logic                 w_accept;
    logic [7:0]           w_byte;
    logic [ADDR_BITS-1:0] w_cell_addr, w_lb_down, w_lb_up, w_fc_next, w_fill_next;
    logic [ADDR_BITS:0]   w_cell_index;

    assign w_accept     = bus.in_valid & r_in_ready;
    assign w_byte       = bus.in_data;
    assign w_cell_index = (ADDR_BITS+1)'(r_cur_y) * (ADDR_BITS+1)'(COLS) + (ADDR_BITS+1)'(r_cur_x);

    buffer_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_cell (
        .i_base(r_line_base), .i_offset(ADDR_BITS'(r_cur_x)), .o_addr(w_cell_addr));
    buffer_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_down (
        .i_base(r_line_base), .i_offset(L_COLS), .o_addr(w_lb_down));
    // Moving up one row is adding (size - COLS), which keeps a single wrap.
    buffer_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_up (
        .i_base(r_line_base), .i_offset(L_UP), .o_addr(w_lb_up));
    buffer_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_fc (
        .i_base(r_first_char), .i_offset(L_COLS), .o_addr(w_fc_next));
    buffer_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_fill (
        .i_base(r_fill_addr), .i_offset(L_ONE), .o_addr(w_fill_next));

`ifdef VT52_DIRECT_CURSOR_EN
    logic [ROW_BITS-1:0]  r_y_row, w_y_row;
    logic [7:0]           w_byte_off;
    logic [ROW_BITS-1:0]  w_row_clamp;
    logic [COL_BITS-1:0]  w_col_clamp;
    logic [ADDR_BITS-1:0] w_lb_direct;

    assign w_byte_off  = (w_byte < CH_SPACE) ? 8'h00 : (w_byte - CH_SPACE);
    assign w_row_clamp = (w_byte_off > 8'(ROWS - 1)) ? L_LAST_Y : w_byte_off[ROW_BITS-1:0];
    assign w_col_clamp = (w_byte_off > 8'(COLS - 1)) ? L_LAST_X : w_byte_off[COL_BITS-1:0];

    buffer_addr_wrap #(.ADDR_BITS(ADDR_BITS), .PAST_LAST_ROW(PAST_LAST_ROW)) u_direct (
        .i_base(r_first_char),
        .i_offset(ADDR_BITS'({r_y_row, 6'b0}) + ADDR_BITS'({r_y_row, 4'b0})),
        .o_addr(w_lb_direct));
`endif

    // FSM state register; reset restarts the full-screen clear.
    always_ff @(posedge clk) begin
        if (!clr) r_state <= ST_FILL;
        else      r_state <= w_state;
    end

    // Next-state and next-output decode for every byte and fill step.
    always_comb begin
        w_state     = r_state;
        w_x         = r_cur_x;
        w_y         = r_cur_y;
        w_fc        = r_first_char;
        w_lb        = r_line_base;
        w_fill_addr = r_fill_addr;
        w_fill_cnt  = r_fill_cnt;
        w_waddr     = r_waddr;
        w_din       = r_din;
        w_wen       = 1'b0;
        w_fc_wen    = 1'b0;
        w_cur_wen   = 1'b0;
`ifdef VT52_DIRECT_CURSOR_EN
        w_y_row     = r_y_row;
`endif
        case (r_state)
            ST_IDLE: if (w_accept) begin
                if ((w_byte >= CH_SPACE) && (w_byte <= CH_TILDE)) begin
                    w_waddr = w_cell_addr;
                    w_din   = w_byte;
                    w_wen   = 1'b1;
                    if (r_cur_x < L_LAST_X) begin
                        w_x       = r_cur_x + COL_BITS'(1);
                        w_cur_wen = 1'b1;
                    end
                end else begin
                    case (w_byte)
                        CH_CR: if (r_cur_x != '0) begin
                            w_x       = '0;
                            w_cur_wen = 1'b1;
                        end
                        CH_BS: if (r_cur_x != '0) begin
                            w_x       = r_cur_x - COL_BITS'(1);
                            w_cur_wen = 1'b1;
                        end
                        CH_LF: if (r_cur_y < L_LAST_Y) begin
                            w_y       = r_cur_y + ROW_BITS'(1);
                            w_lb      = w_lb_down;
                            w_cur_wen = 1'b1;
                        end else begin
                            // Old top line becomes the bottom line; with the
                            // cursor on the last row its base is the old origin.
                            w_state     = ST_SCROLL;
                            w_fc        = w_fc_next;
                            w_fc_wen    = 1'b1;
                            w_fill_addr = r_first_char;
                            w_fill_cnt  = (ADDR_BITS+1)'(COLS);
                            w_lb        = r_first_char;
                        end
                        CH_ESC:  w_state = ST_ESC;
                        default: ;
                    endcase
                end
            end
            ST_ESC: if (w_accept) begin
                w_state = ST_IDLE;
                case (w_byte)
                    CH_ESC: w_state = ST_ESC;
                    8'h41: if (r_cur_y != '0) begin
                        w_y       = r_cur_y - ROW_BITS'(1);
                        w_lb      = w_lb_up;
                        w_cur_wen = 1'b1;
                    end
                    8'h42: if (r_cur_y < L_LAST_Y) begin
                        w_y       = r_cur_y + ROW_BITS'(1);
                        w_lb      = w_lb_down;
                        w_cur_wen = 1'b1;
                    end
                    8'h43: if (r_cur_x < L_LAST_X) begin
                        w_x       = r_cur_x + COL_BITS'(1);
                        w_cur_wen = 1'b1;
                    end
                    8'h44: if (r_cur_x != '0) begin
                        w_x       = r_cur_x - COL_BITS'(1);
                        w_cur_wen = 1'b1;
                    end
                    8'h48: begin
                        w_x       = '0;
                        w_y       = '0;
                        w_lb      = r_first_char;
                        w_cur_wen = (r_cur_x != '0) || (r_cur_y != '0);
                    end
                    8'h4A: begin
                        w_state     = ST_FILL;
                        w_fill_addr = w_cell_addr;
                        w_fill_cnt  = L_PLR - w_cell_index;
                    end
                    8'h4B: begin
                        w_state     = ST_FILL;
                        w_fill_addr = w_cell_addr;
                        w_fill_cnt  = (ADDR_BITS+1)'(COLS) - (ADDR_BITS+1)'(r_cur_x);
                    end
`ifdef VT52_DIRECT_CURSOR_EN
                    8'h59: w_state = ST_ESC_Y_ROW;
`endif
                    default: ;
                endcase
            end
`ifdef VT52_DIRECT_CURSOR_EN
            ST_ESC_Y_ROW: if (w_accept) begin
                w_y_row = w_row_clamp;
                w_state = ST_ESC_Y_COL;
            end
            ST_ESC_Y_COL: if (w_accept) begin
                w_x       = w_col_clamp;
                w_y       = r_y_row;
                w_lb      = w_lb_direct;
                w_cur_wen = 1'b1;
                w_state   = ST_IDLE;
            end
`endif
            ST_SCROLL: w_state = ST_FILL;
            ST_FILL: begin
                w_waddr     = r_fill_addr;
                w_din       = CH_SPACE;
                w_wen       = 1'b1;
                w_fill_addr = w_fill_next;
                w_fill_cnt  = r_fill_cnt - (ADDR_BITS+1)'(1);
                if (r_fill_cnt == (ADDR_BITS+1)'(1)) w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // Datapath and output registers; reset arms a clear of the whole buffer.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_first_char <= '0;
            r_line_base  <= '0;
            r_fill_addr  <= '0;
            r_fill_cnt   <= L_PLR;
            r_waddr      <= '0;
            r_din        <= '0;
            r_wen        <= 1'b0;
            r_fc_wen     <= 1'b0;
            r_cur_wen    <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b1;
`ifdef VT52_DIRECT_CURSOR_EN
            r_y_row      <= '0;
`endif
        end else begin
            r_cur_x      <= w_x;
            r_cur_y      <= w_y;
            r_first_char <= w_fc;
            r_line_base  <= w_lb;
            r_fill_addr  <= w_fill_addr;
            r_fill_cnt   <= w_fill_cnt;
            r_waddr      <= w_waddr;
            r_din        <= w_din;
            r_wen        <= w_wen;
            r_fc_wen     <= w_fc_wen;
            r_cur_wen    <= w_cur_wen;
            r_busy       <= (w_state == ST_FILL) || (w_state == ST_SCROLL);
`ifdef VT52_DIRECT_CURSOR_EN
            r_y_row      <= w_y_row;
            r_in_ready   <= (w_state == ST_IDLE) || (w_state == ST_ESC) ||
                            (w_state == ST_ESC_Y_ROW) || (w_state == ST_ESC_Y_COL);
`else
            r_in_ready   <= (w_state == ST_IDLE) || (w_state == ST_ESC);
`endif
        end
    end

    assign bus.in_ready              = r_in_ready;
    assign bus.busy                  = r_busy;
    assign bus.buffer_waddr          = r_waddr;
    assign bus.buffer_din            = r_din;
    assign bus.buffer_wen            = r_wen;
    assign bus.buffer_first_char     = r_first_char;
    assign bus.buffer_first_char_wen = r_fc_wen;
    assign bus.new_cursor_x          = r_cur_x;
    assign bus.new_cursor_y          = r_cur_y;
    assign bus.new_cursor_wen        = r_cur_wen;
endmodule

// File: doc/command_handler.md
Name: command_handler

Overview:
- Upstream stage of the char generator: consumes the incoming terminal byte stream and converts it into writes to the character buffer, cursor position updates, and scroll (first-char) updates.
- Implements VT52-style control: printable characters, CR, LF, BS, and ESC A/B/C/D/H/J/K.
- Owns the circular screen buffer model: ROWS*COLS cells; the line start rotates with first_char.

Parameters:
- ROWS, 24, text rows
- COLS, 80, text columns
- ROW_BITS, 5, cursor row width
- COL_BITS, 7, cursor column width
- ADDR_BITS, 11, buffer address width
- PAST_LAST_ROW, ROWS*COLS, buffer size (1920); addresses wrap modulo this value

Ports:
- clk  in  1  system clock (48 MHz)
- clr  in  1  synchronous, active-low reset; sampled on posedge clk
- in_data  in  8  received byte
- in_valid  in  1  byte available
- in_ready  out  1  byte accepted when in_valid & in_ready at posedge
- busy  out  1  fill/scroll in progress
- buffer_waddr  out  ADDR_BITS  char buffer write address
- buffer_din  out  8  char buffer write data
- buffer_wen  out  1  one-cycle write strobe
- buffer_first_char  out  ADDR_BITS  new scroll origin
- buffer_first_char_wen  out  1  one-cycle strobe
- new_cursor_x  out  COL_BITS  cursor column
- new_cursor_y  out  ROW_BITS  cursor row
- new_cursor_wen  out  1  one-cycle strobe

Behaviour:
- All outputs registered. While clr=0: all strobes 0, cursor (0,0), first_char 0, in_ready 0, busy 1. FSM enters FILL from address 0, count 1920.
- Reset asserted mid-operation aborts everything and restarts the full clear.
- States: IDLE, ESC, FILL, SCROLL, plus ESC_Y_ROW and ESC_Y_COL (macro only).
- in_ready = 1 only in IDLE, ESC, ESC_Y_*.
- line_base register = (first_char + y*COLS) mod PAST_LAST_ROW.
  - On y±1: add or subtract COLS with a single wrap correction.
- Write address = line_base + x; subtract PAST_LAST_ROW if the sum is >= PAST_LAST_ROW.
- Accepted byte -> resulting strobes on the next cycle (latency 1).
- Printable byte (0x20-0x7E), IDLE:
  - Write byte at (x,y).
  - If x < COLS-1, x+1, else x stays (no autowrap).
  - new_cursor_wen pulses in the same cycle as buffer_wen.
- CR (0x0D): x = 0.
- BS (0x08): x-1 if x > 0, else no-op (no strobe).
- LF (0x0A):
  - If y < ROWS-1: y+1.
  - If y = ROWS-1: SCROLL. first_char += COLS (1920 wraps to 0), pulse buffer_first_char_wen, then FILL the old top line (now the bottom) with 0x20 over COLS cycles. Cursor is unchanged.
- ESC (0x1B): go to ESC. The next byte is decoded, then return to IDLE:
  - 'A': up; no-op at row 0.
  - 'B': down; no-op at ROWS-1, no scroll.
  - 'C': right; no-op at COLS-1.
  - 'D': left; no-op at col 0.
  - 'H': home (0,0).
  - 'J': FILL from (x,y) to end of screen.
  - 'K': FILL from (x,y) to end of line.
  - Any other byte: ignored.
- ESC ESC: remains in ESC.
- Other control bytes and 0x7F-0xFF: ignored.
- FILL: one 0x20 write per cycle, addresses wrapping, count = remaining cells. Then IDLE; cursor unchanged.
- Cursor strobes occur only on an actual position change.

Optional Feature:
- Macro: VT52_DIRECT_CURSOR_EN
- Defined: ESC 'Y' row col.
  - row = byte-0x20, clamped to ROWS-1; col = byte-0x20, clamped to COLS-1.
  - Bytes below 0x20 clamp to 0.
  - line_base is recomputed as first_char + row*64 + row*16 with one wrap subtract.
  - new_cursor_wen fires one cycle after the col byte.
- Undefined: 'Y' in ESC is ignored like any unknown byte; the ESC_Y states are absent.

Decomposition:
- Shared package: state enum, control-byte constants (CR, LF, BS, ESC, SPACE), and ROWS/COLS/PAST_LAST_ROW defaults.
- One sub-module, buffer_addr_wrap: adds base+offset modulo PAST_LAST_ROW; used for write address, line_base and first_char updates.

Test Plan:
- Release reset -> exactly 1920 writes of 0x20, addresses 0..1919 in order; then in_ready=1, cursor (0,0).
- Send 'A' at (0,0) -> waddr 0, din 0x41, cursor (1,0), both strobes in the same cycle. At col 79, 'B' -> waddr 79, cursor stays 79.
- LF x24 from row 0 -> after the 23rd, y=23. 24th: first_char_wen with 80, then 80 writes 0x20 at addresses 0..79, in_ready low throughout.
- first_char=1840, cursor (5,1) -> 'Z' writes address 5 (wrapped). ESC K at (10,2), first_char=80 -> 70 writes at addresses 250..319.
- BS at col 0, ESC A at row 0, ESC Q -> no strobes; FSM back in IDLE.
- With macro: ESC Y 0x37 0x2F -> cursor (15,23). ESC Y 0x7F 0x10 -> cursor (0,23) via row clamp and sub-0x20 col.
